// File: rtl/rf_spill_stack.sv
// LIFO backing store answering the windowed register file's spill/fill traffic.
// Spilled words are pushed one per strobe; a fill pops one whole window, last word first.
module rf_spill_stack #(
    parameter int unsigned NBITS     = 64,
    parameter int unsigned N         = 3,
    parameter int unsigned DEPTH_WIN = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             SPILL,
    input  logic [NBITS-1:0]                 MEM_BUS,
    input  logic                             FILL,
    input  logic                             ERR_CLR,
    output logic [NBITS-1:0]                 MEM_BUSread,
    output logic                             FILL_VALID,
    output logic                             BUSY,
    output logic                             FULL,
    output logic                             EMPTY,
    output logic [$clog2(DEPTH_WIN+1)-1:0]   WIN_COUNT,
    output logic                             OVERFLOW,
    output logic                             UNDERFLOW,
    output logic                             PROTO_ERR
);

    localparam int unsigned WPW       = 2 * N;
    localparam int unsigned MEM_WORDS = DEPTH_WIN * WPW;
    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned PW        = $clog2(MEM_WORDS + 1);
    localparam int unsigned WCW       = $clog2(WPW + 1);
    localparam int unsigned CW        = $clog2(DEPTH_WIN + 1);

    typedef enum logic [1:0] {StIdle, StSpill, StFill} state_e;

    state_e           state;
    logic [PW-1:0]    wp;
    logic [WCW-1:0]   wc;
    logic [CW-1:0]    win_count;

    logic [NBITS-1:0] mem [MEM_WORDS];
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             mem_we;
    logic [NBITS-1:0] rd_data;

    always_comb begin
        wr_addr = AW'(wp);
        rd_addr = AW'(wp - PW'(1));
        rd_data = mem[rd_addr];
        mem_we  = 1'b0;
        if (state == StIdle && SPILL && !FULL) begin
            mem_we = 1'b1;
        end else if (state == StSpill && SPILL) begin
            mem_we = 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wr_addr] <= MEM_BUS;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= StIdle;
            wp          <= '0;
            wc          <= '0;
            win_count   <= '0;
            MEM_BUSread <= '0;
            FILL_VALID  <= 1'b0;
            OVERFLOW    <= 1'b0;
            UNDERFLOW   <= 1'b0;
            PROTO_ERR   <= 1'b0;
        end else begin
            // Clear first so any error raised below on this edge takes precedence.
            if (ERR_CLR) begin
                OVERFLOW  <= 1'b0;
                UNDERFLOW <= 1'b0;
                PROTO_ERR <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    FILL_VALID <= 1'b0;
                    if (SPILL) begin
                        if (FILL) begin
                            PROTO_ERR <= 1'b1;
                        end
                        if (FULL) begin
                            OVERFLOW <= 1'b1;
                        end else begin
                            wp <= wp + PW'(1);
                            if (WPW == 1) begin
                                win_count <= win_count + CW'(1);
                            end else begin
                                wc    <= WCW'(1);
                                state <= StSpill;
                            end
                        end
                    end else if (FILL) begin
                        if (EMPTY) begin
                            UNDERFLOW <= 1'b1;
                        end else begin
                            MEM_BUSread <= rd_data;
                            FILL_VALID  <= 1'b1;
                            wp          <= wp - PW'(1);
                            wc          <= WCW'(1);
                            state       <= StFill;
                        end
                    end
                end
                StSpill: begin
                    if (FILL) begin
                        PROTO_ERR <= 1'b1;
                    end
                    if (SPILL) begin
                        wp <= wp + PW'(1);
                        if (wc == WCW'(WPW - 1)) begin
                            win_count <= win_count + CW'(1);
                            wc        <= '0;
                            state     <= StIdle;
                        end else begin
                            wc <= wc + WCW'(1);
                        end
                    end
                end
                StFill: begin
                    if (SPILL) begin
                        PROTO_ERR <= 1'b1;
                    end
                    if (wc < WCW'(WPW)) begin
                        MEM_BUSread <= rd_data;
                        FILL_VALID  <= 1'b1;
                        wp          <= wp - PW'(1);
                        wc          <= wc + WCW'(1);
                    end else begin
                        FILL_VALID <= 1'b0;
                        win_count  <= win_count - CW'(1);
                        wc         <= '0;
                        state      <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign BUSY      = (state != StIdle);
    assign FULL      = (win_count == CW'(DEPTH_WIN));
    assign EMPTY     = (win_count == '0);
    assign WIN_COUNT = win_count;

endmodule

// File: tb/tb_rf_spill_stack.sv
// Directed bench for rf_spill_stack (N=3, DEPTH_WIN=4): spill/fill ordering, stall,
// overflow, underflow, protocol errors and mid-fill reset.
module tb_rf_spill_stack;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SPILL;
    logic [63:0] MEM_BUS;
    logic        FILL;
    logic        ERR_CLR;
    logic [63:0] MEM_BUSread;
    logic        FILL_VALID;
    logic        BUSY;
    logic        FULL;
    logic        EMPTY;
    logic [2:0]  WIN_COUNT;
    logic        OVERFLOW;
    logic        UNDERFLOW;
    logic        PROTO_ERR;

    int n_chk = 0;
    int n_bad = 0;

    rf_spill_stack #(
        .NBITS     (64),
        .N         (3),
        .DEPTH_WIN (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SPILL       (SPILL),
        .MEM_BUS     (MEM_BUS),
        .FILL        (FILL),
        .ERR_CLR     (ERR_CLR),
        .MEM_BUSread (MEM_BUSread),
        .FILL_VALID  (FILL_VALID),
        .BUSY        (BUSY),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .WIN_COUNT   (WIN_COUNT),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW),
        .PROTO_ERR   (PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Spill words base..base+5; optionally stall 3 cycles after word index stall_at.
    task automatic spill_win(input logic [63:0] base, input int stall_at);
        logic [2:0] wc0;
        wc0 = WIN_COUNT;
        for (int i = 0; i < 6; i++) begin
            SPILL   = 1'b1;
            MEM_BUS = base + 64'(i);
            tick();
            if (i < 5) chk("spill_busy", 64'(BUSY), 64'd1);
            if (i == stall_at) begin
                SPILL = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("stall_busy", 64'(BUSY), 64'd1);
                    chk("stall_wcnt", 64'(WIN_COUNT), 64'(wc0));
                end
            end
        end
        SPILL = 1'b0;
        chk("spill_done_busy", 64'(BUSY), 64'd0);
        chk("spill_done_wcnt", 64'(WIN_COUNT), 64'(wc0) + 64'd1);
    endtask

    // Fill one window expected to hold base..base+5; optionally pulse SPILL before word pulse_at.
    task automatic fill_win(input logic [63:0] base, input int pulse_at);
        logic [2:0] wc0;
        wc0  = WIN_COUNT;
        FILL = 1'b1;
        tick();
        FILL = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("fill_valid", 64'(FILL_VALID), 64'd1);
            chk("fill_data", MEM_BUSread, base + 64'(5 - k));
            if (k < 5) begin
                SPILL   = (k == pulse_at);
                MEM_BUS = 64'hdead_beef;
                tick();
                SPILL   = 1'b0;
            end
        end
        tick();
        chk("fill_end_valid", 64'(FILL_VALID), 64'd0);
        chk("fill_end_busy", 64'(BUSY), 64'd0);
        chk("fill_end_wcnt", 64'(WIN_COUNT), 64'(wc0) - 64'd1);
    endtask

    task automatic clear_errs();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("clr_ovf", 64'(OVERFLOW), 64'd0);
        chk("clr_unf", 64'(UNDERFLOW), 64'd0);
        chk("clr_proto", 64'(PROTO_ERR), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET   = 1'b0;
        SPILL   = 1'b0;
        MEM_BUS = '0;
        FILL    = 1'b0;
        ERR_CLR = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();

        // Reset state
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_full", 64'(FULL), 64'd0);
        chk("rst_empty", 64'(EMPTY), 64'd1);
        chk("rst_wcnt", 64'(WIN_COUNT), 64'd0);
        chk("rst_fv", 64'(FILL_VALID), 64'd0);
        chk("rst_rd", MEM_BUSread, 64'd0);
        chk("rst_flags", {61'd0, OVERFLOW, UNDERFLOW, PROTO_ERR}, 64'd0);

        // Basic spill then LIFO fill
        spill_win(64'h10, -1);
        fill_win(64'h10, -1);
        chk("basic_empty", 64'(EMPTY), 64'd1);

        // Stalled spill
        spill_win(64'h20, 2);
        fill_win(64'h20, -1);

        // Fill to FULL, then an overflowing fifth window
        spill_win(64'h100, -1);
        spill_win(64'h200, -1);
        spill_win(64'h300, -1);
        spill_win(64'h400, -1);
        chk("full", 64'(FULL), 64'd1);
        for (int i = 0; i < 6; i++) begin
            SPILL   = 1'b1;
            MEM_BUS = 64'h500 + 64'(i);
            tick();
            chk("ovf_idle", 64'(BUSY), 64'd0);
        end
        SPILL = 1'b0;
        chk("ovf_flag", 64'(OVERFLOW), 64'd1);
        chk("ovf_wcnt", 64'(WIN_COUNT), 64'd4);
        fill_win(64'h400, -1);
        chk("ovf_sticky", 64'(OVERFLOW), 64'd1);
        clear_errs();
        fill_win(64'h300, -1);
        fill_win(64'h200, -1);
        fill_win(64'h100, -1);
        chk("drain_empty", 64'(EMPTY), 64'd1);

        // Underflow
        FILL = 1'b1;
        tick();
        FILL = 1'b0;
        chk("unf_flag", 64'(UNDERFLOW), 64'd1);
        chk("unf_fv", 64'(FILL_VALID), 64'd0);
        chk("unf_busy", 64'(BUSY), 64'd0);
        tick();
        chk("unf_fv2", 64'(FILL_VALID), 64'd0);
        clear_errs();
        // Error set on the same edge as ERR_CLR wins
        FILL    = 1'b1;
        ERR_CLR = 1'b1;
        tick();
        FILL    = 1'b0;
        ERR_CLR = 1'b0;
        chk("set_wins", 64'(UNDERFLOW), 64'd1);
        clear_errs();

        // SPILL and FILL together in IDLE: spill wins
        SPILL   = 1'b1;
        FILL    = 1'b1;
        MEM_BUS = 64'h30;
        tick();
        FILL = 1'b0;
        chk("both_busy", 64'(BUSY), 64'd1);
        chk("both_proto", 64'(PROTO_ERR), 64'd1);
        for (int i = 1; i < 6; i++) begin
            MEM_BUS = 64'h30 + 64'(i);
            tick();
        end
        SPILL = 1'b0;
        chk("both_wcnt", 64'(WIN_COUNT), 64'd1);
        clear_errs();
        // SPILL pulsed mid-fill is dropped
        fill_win(64'h30, 2);
        chk("pulse_proto", 64'(PROTO_ERR), 64'd1);
        chk("pulse_empty", 64'(EMPTY), 64'd1);
        clear_errs();

        // Reset after the third filled word
        spill_win(64'h40, -1);
        FILL = 1'b1;
        tick();
        FILL = 1'b0;
        tick();
        tick();
        chk("prerst_data", MEM_BUSread, 64'h43);
        RESET = 1'b0;
        #1;
        chk("midrst_fv", 64'(FILL_VALID), 64'd0);
        chk("midrst_wcnt", 64'(WIN_COUNT), 64'd0);
        chk("midrst_empty", 64'(EMPTY), 64'd1);
        chk("midrst_busy", 64'(BUSY), 64'd0);
        tick();
        RESET = 1'b1;
        tick();
        spill_win(64'h50, -1);
        fill_win(64'h50, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
